// File: rtl/ctrl_pkg.sv
// Shared constants for the hardwired control unit: T-state encoding, opcodes,
// ALU codes, Datapath enable/bus bit positions and IR field positions.
package ctrl_pkg;

    localparam logic [3:0] StIdle = 4'd0;
    localparam logic [3:0] StT0   = 4'd1;
    localparam logic [3:0] StT1   = 4'd2;
    localparam logic [3:0] StT2   = 4'd3;
    localparam logic [3:0] StT3   = 4'd4;
    localparam logic [3:0] StT4   = 4'd5;
    localparam logic [3:0] StT5   = 4'd6;
    localparam logic [3:0] StT6   = 4'd7;
    localparam logic [3:0] StHalt = 4'd8;

    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpHalt = 5'b11011;

    localparam logic [3:0] AluAdd = 4'd3;
    localparam logic [3:0] AluSub = 4'd4;
    localparam logic [3:0] AluAnd = 4'd5;
    localparam logic [3:0] AluOr  = 4'd6;
    localparam logic [3:0] AluMul = 4'd12;
    localparam logic [3:0] AluDiv = 4'd13;

    localparam int unsigned EnHi    = 16;
    localparam int unsigned EnLo    = 17;
    localparam int unsigned EnPcInc = 20;
    localparam int unsigned EnMdr   = 21;
    localparam int unsigned EnIr    = 23;
    localparam int unsigned EnZ     = 24;
    localparam int unsigned EnMar   = 25;
    localparam int unsigned EnY     = 27;

    localparam int unsigned BusZhigh = 18;
    localparam int unsigned BusZlow  = 19;
    localparam int unsigned BusPc    = 20;
    localparam int unsigned BusMdr   = 21;

    localparam int unsigned IrOpLsb = 27;
    localparam int unsigned IrRaLsb = 23;
    localparam int unsigned IrRbLsb = 19;
    localparam int unsigned IrRcLsb = 15;

    typedef enum logic [1:0] {KindAlu, KindMulDiv, KindHalt, KindBad} op_kind_e;

    function automatic op_kind_e op_kind(input logic [4:0] op);
        case (op)
            OpAdd, OpSub, OpAnd, OpOr: return KindAlu;
            OpMul, OpDiv:              return KindMulDiv;
            OpHalt:                    return KindHalt;
            default:                   return KindBad;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            OpAdd:   return AluAdd;
            OpSub:   return AluSub;
            OpAnd:   return AluAnd;
            OpOr:    return AluOr;
            OpMul:   return AluMul;
            OpDiv:   return AluDiv;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational output decode: (T-state, IR) -> Datapath enables, bus select,
// ALU operation and memory read strobe.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned ALU_W = 4
) (
    input  logic [3:0]       state,
    input  logic [31:0]      ir,
    output logic [31:0]      enable,
    output logic [31:0]      busSelect,
    output logic [ALU_W-1:0] Control_Signals,
    output logic             MR_Read
);

    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    op_kind_e   kind;
    logic       exec_op;
    logic       unused_ir;

    assign op        = ir[IrOpLsb +: 5];
    assign ra        = ir[IrRaLsb +: 4];
    assign rb        = ir[IrRbLsb +: 4];
    assign rc        = ir[IrRcLsb +: 4];
    assign kind      = op_kind(op);
    assign exec_op   = (kind == KindAlu) || (kind == KindMulDiv);
    assign unused_ir = ^ir[IrRcLsb-1:0];

    always_comb begin
        enable          = '0;
        busSelect       = '0;
        Control_Signals = '0;
        MR_Read         = 1'b0;
        case (state)
            StT0: begin
                busSelect[BusPc] = 1'b1;
                enable[EnMar]    = 1'b1;
                enable[EnPcInc]  = 1'b1;
            end
            StT1: begin
                MR_Read       = 1'b1;
                enable[EnMdr] = 1'b1;
            end
            StT2: begin
                busSelect[BusMdr] = 1'b1;
                enable[EnIr]      = 1'b1;
            end
            StT3: begin
                // Y takes the first operand: rb for ALU ops, ra for MUL/DIV.
                if (exec_op) begin
                    enable[EnY] = 1'b1;
                    busSelect[(kind == KindAlu) ? rb : ra] = 1'b1;
                end
            end
            StT4: begin
                if (exec_op) begin
                    enable[EnZ]     = 1'b1;
                    Control_Signals = ALU_W'(alu_code(op));
                    busSelect[(kind == KindAlu) ? rc : rb] = 1'b1;
                end
            end
            StT5: begin
                if (exec_op) begin
                    busSelect[BusZlow] = 1'b1;
                    if (kind == KindAlu) begin
                        enable[ra] = 1'b1;
                    end else begin
                        enable[EnLo] = 1'b1;
                    end
                end
            end
            StT6: begin
                busSelect[BusZhigh] = 1'b1;
                enable[EnHi]        = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired T-state control unit: fetch (T0-T2) then execute R-format ALU ops
// and the two-result MUL/DIV ops, driving the Datapath control inputs.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned ALU_W         = 4,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    output logic [31:0]      enable,
    output logic [31:0]      busSelect,
    output logic [ALU_W-1:0] Control_Signals,
    output logic             MR_Read,
    output logic             busy,
    output logic             instr_done,
    output logic             illegal
);

    localparam int unsigned     CntW    = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FETCH_TIMEOUT - 1);

    logic [3:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic [3:0]      after_done;
    op_kind_e        kind;

    assign kind       = op_kind(ir[IrOpLsb +: 5]);
    assign after_done = run ? StT0 : StIdle;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        illegal_d  = illegal_q;
        instr_done = 1'b0;
        case (state_q)
            StIdle: if (run) state_d = StT0;
            StT0: begin
                cnt_d   = '0;
                state_d = StT1;
            end
            StT1: begin
                // The final wait cycle aborts the fetch unless memory answers in it.
                if (mem_ready) begin
                    state_d = StT2;
                end else if (cnt_q == CntLast) begin
                    illegal_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StT2: state_d = StT3;
            StT3: begin
                case (kind)
                    KindHalt: begin
                        instr_done = 1'b1;
                        state_d    = StHalt;
                    end
                    KindBad: begin
                        instr_done = 1'b1;
                        illegal_d  = 1'b1;
                        state_d    = after_done;
                    end
                    default: state_d = StT4;
                endcase
            end
            StT4: state_d = StT5;
            StT5: begin
                if (kind == KindMulDiv) begin
                    state_d = StT6;
                end else begin
                    instr_done = 1'b1;
                    state_d    = after_done;
                end
            end
            StT6: begin
                instr_done = 1'b1;
                state_d    = after_done;
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    ctrl_decode #(
        .ALU_W(ALU_W)
    ) u_decode (
        .state          (state_q),
        .ir             (ir),
        .enable         (enable),
        .busSelect      (busSelect),
        .Control_Signals(Control_Signals),
        .MR_Read        (MR_Read)
    );

    assign busy    = (state_q != StIdle) && (state_q != StHalt);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench: a cycle-level reference trace per instruction is queued when
// the stimulus is planned; a monitor pops one entry per cycle and compares.
module tb_ctrl_sequencer;

    localparam int TO = 15;

    typedef struct {
        logic [31:0] ir;
        int          wait_cyc;
        bit          last;
        bit          abort;
    } plan_t;

    typedef struct {
        string       tag;
        logic [31:0] en;
        logic [31:0] bus;
        logic [3:0]  cs;
        logic        mr;
        logic        busy;
        logic        done;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        run = 1'b0;
    logic [31:0] ir = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic [3:0]  Control_Signals;
    logic        MR_Read;
    logic        busy;
    logic        instr_done;
    logic        illegal;

    int    checks = 0;
    int    errors = 0;
    exp_t  exp_q[$];
    plan_t plan_q[$];
    plan_t scen[$];
    plan_t cur;
    int    mr_cycles = 0;
    logic  m_ill = 1'b0;

    ctrl_sequencer #(
        .ALU_W(4),
        .FETCH_TIMEOUT(TO)
    ) dut (
        .clk            (clk),
        .clr            (clr),
        .run            (run),
        .ir             (ir),
        .mem_ready      (mem_ready),
        .enable         (enable),
        .busSelect      (busSelect),
        .Control_Signals(Control_Signals),
        .MR_Read        (MR_Read),
        .busy           (busy),
        .instr_done     (instr_done),
        .illegal        (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] b(input int i);
        return 32'd1 << i;
    endfunction

    task automatic push(input string tag, input logic [31:0] en, input logic [31:0] bus,
                        input logic [3:0] cs, input logic mr, input logic bz, input logic dn);
        exp_t e;
        e.tag = tag; e.en = en; e.bus = bus; e.cs = cs;
        e.mr = mr; e.busy = bz; e.done = dn; e.ill = m_ill;
        exp_q.push_back(e);
    endtask

    // Reference: the cycle-by-cycle control word sequence one instruction produces.
    task automatic model_instr(input plan_t p, output bit stop);
        logic [4:0] op;
        logic [3:0] ra, rb, rc, code;
        int         kind;  // 0 undefined, 1 ALU, 2 MUL/DIV, 3 HALT
        int         n;
        op = p.ir[31:27]; ra = p.ir[26:23]; rb = p.ir[22:19]; rc = p.ir[18:15];
        stop = 1'b0;
        code = 4'd0;
        case (op)
            5'b00011: begin kind = 1; code = 4'd3; end
            5'b00100: begin kind = 1; code = 4'd4; end
            5'b00101: begin kind = 1; code = 4'd5; end
            5'b00110: begin kind = 1; code = 4'd6; end
            5'b01111: begin kind = 2; code = 4'd12; end
            5'b10000: begin kind = 2; code = 4'd13; end
            5'b11011: kind = 3;
            default:  kind = 0;
        endcase
        push("T0", b(25) | b(20), b(20), 4'd0, 1'b0, 1'b1, 1'b0);
        n = (p.wait_cyc >= TO) ? TO : p.wait_cyc + 1;
        for (int i = 0; i < n; i++) push("T1", b(21), 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        if (p.wait_cyc >= TO) begin
            m_ill = 1'b1;
            push("IDLE_timeout", 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
            return;
        end
        push("T2", b(23), b(21), 4'd0, 1'b0, 1'b1, 1'b0);
        if (kind == 3) begin
            push("T3_halt", 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b1);
            stop = 1'b1;
            return;
        end
        if (kind == 0) begin
            push("T3_undef", 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b1);
            m_ill = 1'b1;
            return;
        end
        push("T3", b(27), (kind == 1) ? b(rb) : b(ra), 4'd0, 1'b0, 1'b1, 1'b0);
        push("T4", b(24), (kind == 1) ? b(rc) : b(rb), code, 1'b0, 1'b1, 1'b0);
        if (p.abort) begin
            stop = 1'b1;
            return;
        end
        if (kind == 1) begin
            push("T5", b(ra), b(19), 4'd0, 1'b0, 1'b1, 1'b1);
        end else begin
            push("T5", b(17), b(19), 4'd0, 1'b0, 1'b1, 1'b0);
            push("T6", b(16), b(18), 4'd0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic add_plan(input logic [31:0] ir_v, input int w, input bit ab);
        plan_t p;
        p.ir = ir_v; p.wait_cyc = w; p.last = 1'b0; p.abort = ab;
        scen.push_back(p);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 4000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Ends the previous scenario with a clr edge, then plans and models the next one.
    task automatic run_scenario();
        plan_t p;
        bit    stop;
        bit    aborted;
        drain();
        clr = 1'b1;
        run = 1'b0;
        plan_q.delete();
        @(posedge clk);
        #1;
        clr = 1'b0;
        run = 1'b1;
        m_ill = 1'b0;
        push("IDLE_after_clr", 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;
        aborted = 1'b0;
        for (int i = 0; i < scen.size() && !stop; i++) begin
            p = scen[i];
            p.last = (i == scen.size() - 1);
            plan_q.push_back(p);
            model_instr(p, stop);
            aborted = stop && p.abort;
        end
        if (!aborted)
            for (int i = 0; i < 3; i++) push("IDLE_tail", 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        scen.delete();
    endtask

    // Memory/IR side of the Datapath, acting after the monitor's sample point.
    always @(negedge clk) begin
        #2;
        if (enable[25] && plan_q.size() > 0) begin
            cur = plan_q.pop_front();
            if (cur.last) run = 1'b0;
        end
        if (enable[23]) ir = cur.ir;
        if (MR_Read) begin
            mem_ready = (mr_cycles == cur.wait_cyc);
            mr_cycles++;
        end else begin
            mem_ready = 1'b0;
            mr_cycles = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (enable !== e.en || busSelect !== e.bus || Control_Signals !== e.cs ||
                MR_Read !== e.mr || busy !== e.busy || instr_done !== e.done ||
                illegal !== e.ill) begin
                errors++;
                $display("FAIL %s: got en=%h bus=%h cs=%0d mr=%b busy=%b done=%b ill=%b; want en=%h bus=%h cs=%0d mr=%b busy=%b done=%b ill=%b",
                         e.tag, enable, busSelect, Control_Signals, MR_Read, busy, instr_done,
                         illegal, e.en, e.bus, e.cs, e.mr, e.busy, e.done, e.ill);
            end
            checks++;
            if (!$onehot0(busSelect)) begin
                errors++;
                $display("FAIL bus_onehot %s: busSelect=%h, required at most one bit", e.tag,
                         busSelect);
            end
        end
    end

    function automatic logic [4:0] rand_op();
        int         r;
        logic [4:0] o;
        r = $urandom_range(0, 19);
        if (r < 12) begin
            case (r % 4)
                0: o = 5'b00011;
                1: o = 5'b00100;
                2: o = 5'b00101;
                default: o = 5'b00110;
            endcase
        end else if (r < 16) begin
            o = (r % 2 == 0) ? 5'b01111 : 5'b10000;
        end else if (r < 19) begin
            do o = 5'($urandom_range(0, 31));
            while (o inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01111, 5'b10000,
                             5'b11011});
        end else begin
            o = 5'b11011;
        end
        return o;
    endfunction

    function automatic int rand_wait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 3);
        if (r < 8) return $urandom_range(4, 14);
        if (r == 8) return TO - 1;
        return $urandom_range(TO, TO + 5);
    endfunction

    initial begin
        logic [31:0] bits;
        logic [4:0]  op;
        int          n;
        repeat (3) @(negedge clk);
        #1;

        add_plan(32'h7B380000, 0, 1'b0);  // mul r6,r7
        add_plan(32'h18918000, 0, 1'b0);  // add r1,r2,r3
        run_scenario();

        add_plan(32'h18918000, 3, 1'b0);
        add_plan(32'h18918000, TO - 1, 1'b0);
        add_plan(32'h18918000, TO, 1'b0);
        run_scenario();

        add_plan({5'b11111, 27'd0}, 0, 1'b0);
        add_plan(32'h18918000, 0, 1'b0);
        add_plan({5'b11011, 27'd0}, 0, 1'b0);
        run_scenario();

        add_plan({5'b11111, 27'd0}, 0, 1'b0);
        add_plan({5'b10000, 4'd2, 4'd9, 4'd0, 15'd0}, 1, 1'b1);  // clr lands after T4
        run_scenario();

        add_plan(32'h18918000, 0, 1'b0);
        run_scenario();

        for (int s = 0; s < 25; s++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                op = rand_op();
                bits = $urandom();
                add_plan({op, bits[26:0]}, rand_wait(), 1'b0);
                if (op == 5'b11011) break;
            end
            run_scenario();
        end

        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
